// File: rtl/abd_rd_arbiter_pkg.sv
// Shared types and build-time constants for the AmorphOS F1 ABD read-path arbiter.
package AOSF1Types;

    typedef struct packed {
        logic [63:0] addr;
    } ABDReadReq;

    localparam int F1_ABDRdArb_NumReq         = 4;
    localparam int F1_ABDRdArb_MaxOutstanding = 16;

    // LUTRAM storage cannot be reset; the flop flavour clears its contents on reset.
    typedef enum logic [0:0] {
        ROUTE_FIFO_LUTRAM = 1'b0,
        ROUTE_FIFO_FLOPS  = 1'b1
    } route_fifo_type_e;

    localparam route_fifo_type_e F1_ABDRdArb_RouteFIFO_Type = ROUTE_FIFO_LUTRAM;

endpackage

// File: rtl/abd_rd_arbiter_fifo.sv
// Show-ahead FIFO; q presents the head entry whenever empty is low.
module HullFIFO
    import AOSF1Types::*;
#(
    parameter int               WIDTH     = 2,
    parameter int               LOG_DEPTH = 4,
    parameter route_fifo_type_e FIFO_TYPE = ROUTE_FIFO_LUTRAM
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic                 wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == (LOG_DEPTH+1)'(DEPTH));
    assign rd_en = rdreq && !empty;
    // A dequeue in the same cycle frees the slot, so a full FIFO may still accept.
    assign wr_en = wrreq && (!full || rd_en);
    assign q     = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + LOG_DEPTH'(wr_en);
        rd_ptr_d = rd_ptr_q + LOG_DEPTH'(rd_en);
        count_d  = count_q + (LOG_DEPTH+1)'(wr_en) - (LOG_DEPTH+1)'(rd_en);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if (FIFO_TYPE == ROUTE_FIFO_FLOPS) begin : g_flops
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (wr_en) begin
                mem[wr_ptr_q] <= data;
            end
        end
    end else begin : g_lutram
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr_q] <= data;
        end
    end

endmodule

// File: rtl/abd_rd_arbiter.sv
// Round-robin arbiter sharing the ABD read port between NUM_REQ requesters,
// with credit-bounded issue and in-order response routing via a requester-index FIFO.
module abd_rd_arbiter
    import AOSF1Types::*;
#(
    parameter int NUM_REQ         = F1_ABDRdArb_NumReq,
    parameter int MAX_OUTSTANDING = F1_ABDRdArb_MaxOutstanding,
    parameter int LOG_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*64-1:0]      req_addr,
    output logic [NUM_REQ-1:0]         req_accept,
    output logic                       read_req_packet_valid,
    output logic [63:0]                read_req_packet_addr,
    input  logic                       read_req_accept,
    input  logic                       read_resp_packet_valid,
    input  logic [511:0]               read_resp_packet_data,
    output logic                       accept_read_resp_packet,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [511:0]               resp_data,
    input  logic [NUM_REQ-1:0]         resp_accept,
    output logic [LOG_OUTSTANDING:0]   outstanding,
    output logic                       err_orphan_resp
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = LOG_OUTSTANDING + 1;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Descending scan so the candidate closest to ptr is the last one written.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            r;
        logic [IDX_W-1:0] cand;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

    logic [63:0]      addr_arr [NUM_REQ];
    ABDReadReq        stage_q, stage_d;
    logic             stage_valid_q, stage_valid_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic             err_q, err_d;

    pick_t            pick;
    logic             drain, can_load, grant;
    logic             route_full, route_empty;
    logic [IDX_W-1:0] route_head;
    logic             resp_hs, orphan;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*64 +: 64];
    end

    assign pick     = rr_pick(req_valid, rr_ptr_q);
    assign drain    = stage_valid_q && read_req_accept;
    assign can_load = !stage_valid_q || drain;
    assign grant    = rst_n && can_load && (outst_q < CNT_W'(MAX_OUTSTANDING))
                      && !route_full && pick.found;

    always_comb begin
        req_accept    = '0;
        stage_d       = stage_q;
        stage_valid_d = stage_valid_q;
        rr_ptr_d      = rr_ptr_q;
        if (grant) begin
            req_accept[pick.idx] = 1'b1;
            stage_d.addr         = addr_arr[pick.idx];
            stage_valid_d        = 1'b1;
            rr_ptr_d             = IDX_W'((int'(pick.idx) + 1) % NUM_REQ);
        end else if (drain) begin
            stage_valid_d = 1'b0;
        end
    end

    assign read_req_packet_valid = stage_valid_q;
    assign read_req_packet_addr  = stage_q.addr;

    // Responses return in issue order, so the FIFO head names their owner.
    HullFIFO #(
        .WIDTH     (IDX_W),
        .LOG_DEPTH (LOG_OUTSTANDING),
        .FIFO_TYPE (F1_ABDRdArb_RouteFIFO_Type)
    ) u_route_fifo (
        .clk     (clk),
        .reset_n (rst_n),
        .wrreq   (grant),
        .data    (pick.idx),
        .full    (route_full),
        .rdreq   (resp_hs),
        .q       (route_head),
        .empty   (route_empty)
    );

    assign resp_hs   = read_resp_packet_valid && !route_empty && resp_accept[route_head];
    assign orphan    = rst_n && read_resp_packet_valid && route_empty;
    assign resp_data = read_resp_packet_data;
    assign accept_read_resp_packet =
        rst_n && (route_empty ? read_resp_packet_valid : resp_accept[route_head]);

    always_comb begin
        resp_valid = '0;
        if (read_resp_packet_valid && !route_empty) resp_valid[route_head] = 1'b1;
    end

    always_comb begin
        outst_d = outst_q;
        unique case ({grant, resp_hs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        err_d = err_q || orphan;
    end

    assign outstanding     = outst_q;
    assign err_orphan_resp = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q       <= '0;
            stage_valid_q <= 1'b0;
            rr_ptr_q      <= '0;
            outst_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            rr_ptr_q      <= rr_ptr_d;
            outst_q       <= outst_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_abd_rd_arbiter.sv
// Bench for abd_rd_arbiter: queue-based reference model checked every cycle plus directed scenarios.
module tb_abd_rd_arbiter;

    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid, req_accept, resp_valid, resp_accept;
    logic [NR*64-1:0]  req_addr;
    logic [63:0]       rq_addr [NR];
    logic              read_req_packet_valid, read_req_accept;
    logic [63:0]       read_req_packet_addr;
    logic              read_resp_packet_valid, accept_read_resp_packet, err_orphan_resp;
    logic [511:0]      read_resp_packet_data, resp_data;
    logic [4:0]        outstanding;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        for (int i = 0; i < NR; i++) req_addr[i*64 +: 64] = rq_addr[i];
    end

    abd_rd_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(16), .LOG_OUTSTANDING(4)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .req_valid               (req_valid),
        .req_addr                (req_addr),
        .req_accept              (req_accept),
        .read_req_packet_valid   (read_req_packet_valid),
        .read_req_packet_addr    (read_req_packet_addr),
        .read_req_accept         (read_req_accept),
        .read_resp_packet_valid  (read_resp_packet_valid),
        .read_resp_packet_data   (read_resp_packet_data),
        .accept_read_resp_packet (accept_read_resp_packet),
        .resp_valid              (resp_valid),
        .resp_data               (resp_data),
        .resp_accept             (resp_accept),
        .outstanding             (outstanding),
        .err_orphan_resp         (err_orphan_resp)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Round-robin rule: first set bit scanning upward from p, wrapping at NR.
    function automatic logic [2:0] rr_model(input logic [NR-1:0] v, input logic [1:0] p);
        for (int k = 0; k < NR; k++) begin
            logic [1:0] c;
            c = p + 2'(k);
            if (v[c]) return {1'b1, c};
        end
        return 3'b000;
    endfunction

    // Reference model: outstanding reads are simply the queue of owners still owed a response.
    bit         m_sv;
    logic [63:0] m_sa;
    logic [1:0] m_ptr;
    logic [1:0] m_route [$];
    bit         m_err;

    always @(negedge clk) begin : model
        logic [2:0]    pk;
        logic [NR-1:0] e_acc, e_rv;
        logic          e_ara, hs, can;
        if (!rst_n) begin
            m_sv = 1'b0; m_sa = '0; m_ptr = '0; m_err = 1'b0;
            m_route.delete();
            chk("rst_req_accept", req_accept, '0);
            chk("rst_rd_req_valid", read_req_packet_valid, '0);
            chk("rst_rd_req_addr", read_req_packet_addr, '0);
            chk("rst_resp_valid", resp_valid, '0);
            chk("rst_accept_resp", accept_read_resp_packet, '0);
            chk("rst_outstanding", outstanding, '0);
            chk("rst_err", err_orphan_resp, '0);
        end else begin
            can   = !m_sv || read_req_accept;
            pk    = (can && m_route.size() < 16) ? rr_model(req_valid, m_ptr) : 3'b000;
            e_acc = pk[2] ? (NR'(1) << pk[1:0]) : '0;
            e_rv  = '0;
            e_ara = read_resp_packet_valid;
            if (m_route.size() > 0) begin
                if (read_resp_packet_valid) e_rv = NR'(1) << m_route[0];
                e_ara = resp_accept[m_route[0]];
            end
            chk("m_req_accept", req_accept, e_acc);
            chk("m_rd_req_valid", read_req_packet_valid, m_sv);
            chk("m_rd_req_addr", read_req_packet_addr, m_sa);
            chk("m_resp_valid", resp_valid, e_rv);
            chk("m_accept_resp", accept_read_resp_packet, e_ara);
            chk("m_outstanding", outstanding, m_route.size());
            chk("m_err", err_orphan_resp, m_err);
            if (e_rv != '0) chk("m_resp_data", resp_data, read_resp_packet_data);

            hs = read_resp_packet_valid && (m_route.size() > 0) && resp_accept[m_route[0]];
            if (read_resp_packet_valid && m_route.size() == 0) m_err = 1'b1;
            if (hs) void'(m_route.pop_front());
            if (pk[2]) begin
                m_sv  = 1'b1;
                m_sa  = rq_addr[pk[1:0]];
                m_route.push_back(pk[1:0]);
                m_ptr = pk[1:0] + 2'd1;
            end else if (m_sv && read_req_accept) begin
                m_sv = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        at_neg();
        tick();
        rst_n = 1'b1;
    endtask

    // Return responses with all requesters ready until the last owed one is taken.
    task automatic drain_responses(input string nm);
        bit done, last;
        done = 1'b0;
        resp_accept = '1;
        read_resp_packet_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            read_resp_packet_data = {16{$urandom}};
            at_neg();
            last = (outstanding == 5'd1) && accept_read_resp_packet;
            tick();
            if (last) done = 1'b1;
        end
        read_resp_packet_valid = 1'b0;
        chk(nm, done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        int order [6] = '{0, 1, 2, 3, 0, 1};
        logic [511:0] d0, r0, r1, r2;

        rst_n = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) rq_addr[i] = '0;
        read_req_accept = 1'b1;
        read_resp_packet_valid = 1'b0;
        read_resp_packet_data = '0;
        resp_accept = '1;
        at_neg();
        tick();
        rst_n = 1'b1;

        // Single requester round trip.
        tick();
        rq_addr[2] = 64'h1000;
        req_valid = 4'b0100;
        at_neg();
        chk("single_grant", req_accept, 4'b0100);
        chk("single_outst0", outstanding, 5'd0);
        tick();
        req_valid = '0;
        at_neg();
        chk("single_req_valid", read_req_packet_valid, 1'b1);
        chk("single_req_addr", read_req_packet_addr, 64'h1000);
        chk("single_outst1", outstanding, 5'd1);
        repeat (4) tick();
        d0 = {16{32'hD0D0_0001}};
        read_resp_packet_valid = 1'b1;
        read_resp_packet_data = d0;
        at_neg();
        chk("single_resp_valid", resp_valid, 4'b0100);
        chk("single_resp_data", resp_data, d0);
        chk("single_resp_accept", accept_read_resp_packet, 1'b1);
        tick();
        read_resp_packet_valid = 1'b0;
        at_neg();
        chk("single_outst_back", outstanding, 5'd0);

        // Round-robin fairness from a fresh pointer.
        tick();
        do_reset();
        for (int i = 0; i < NR; i++) rq_addr[i] = 64'h1_0000 * (i + 1);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            chk($sformatf("rr_grant_%0d", k), req_accept, 4'(1) << order[k]);
            tick();
        end
        req_valid = '0;
        at_neg();
        chk("rr_outst6", outstanding, 5'd6);
        tick();
        drain_responses("rr_drain");

        // Credit limit with requester 0 asking continuously.
        rq_addr[0] = 64'h2000;
        req_valid = 4'b0001;
        ng = 0;
        repeat (24) begin
            at_neg();
            if (req_accept != '0) ng++;
            tick();
        end
        chk("credit_grants", ng, 16);
        at_neg();
        chk("credit_outst16", outstanding, 5'd16);
        chk("credit_blocked", req_accept, 4'b0000);
        tick();
        read_resp_packet_valid = 1'b1;
        read_resp_packet_data = {16{32'hC0FF_EE00}};
        at_neg();
        tick();
        read_resp_packet_valid = 1'b0;
        ng = 0;
        repeat (5) begin
            at_neg();
            if (req_accept != '0) ng++;
            tick();
        end
        chk("credit_one_more", ng, 1);
        req_valid = '0;
        drain_responses("credit_drain");

        // Backpressure: ABD stalls for 10 cycles.
        rq_addr[1] = 64'h3040;
        rq_addr[2] = 64'h3080;
        req_valid = 4'b0110;
        read_req_accept = 1'b0;
        ng = 0;
        repeat (10) begin
            at_neg();
            if (req_accept != '0) ng++;
            tick();
        end
        chk("bp_single_grant", ng, 1);
        at_neg();
        chk("bp_stage_valid", read_req_packet_valid, 1'b1);
        chk("bp_stage_addr", read_req_packet_addr, 64'h3040);
        tick();
        read_req_accept = 1'b1;
        at_neg();
        chk("bp_resume_grant", req_accept, 4'b0100);
        tick();
        req_valid = '0;
        drain_responses("bp_drain");

        // Head-of-line stall on requester 3.
        rq_addr[1] = 64'h4000;
        rq_addr[3] = 64'h4100;
        req_valid = 4'b0010;
        at_neg(); chk("route_g0", req_accept, 4'b0010); tick();
        req_valid = 4'b1000;
        at_neg(); chk("route_g1", req_accept, 4'b1000); tick();
        req_valid = 4'b0010;
        at_neg(); chk("route_g2", req_accept, 4'b0010); tick();
        req_valid = '0;
        r0 = {16{32'hAAAA_0000}};
        r1 = {16{32'hBBBB_1111}};
        r2 = {16{32'hCCCC_2222}};
        resp_accept = 4'b0111;
        read_resp_packet_valid = 1'b1;
        read_resp_packet_data = r0;
        at_neg();
        chk("route_r0_valid", resp_valid, 4'b0010);
        chk("route_r0_data", resp_data, r0);
        tick();
        read_resp_packet_data = r1;
        repeat (4) begin
            at_neg();
            chk("route_r1_held", resp_valid, 4'b1000);
            chk("route_r1_stalled", accept_read_resp_packet, 1'b0);
            tick();
        end
        resp_accept = 4'b1111;
        at_neg();
        chk("route_r1_valid", resp_valid, 4'b1000);
        chk("route_r1_taken", accept_read_resp_packet, 1'b1);
        tick();
        read_resp_packet_data = r2;
        at_neg();
        chk("route_r2_valid", resp_valid, 4'b0010);
        chk("route_r2_data", resp_data, r2);
        tick();
        read_resp_packet_valid = 1'b0;
        at_neg();
        chk("route_outst0", outstanding, 5'd0);

        // Async reset with three reads in flight, then an orphan response.
        tick();
        req_valid = 4'b0111;
        repeat (3) tick();
        req_valid = '0;
        at_neg();
        chk("rst_pre_outst3", outstanding, 5'd3);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_outst", outstanding, 5'd0);
        chk("arst_rd_req_valid", read_req_packet_valid, 1'b0);
        chk("arst_rd_req_addr", read_req_packet_addr, 64'h0);
        chk("arst_resp_valid", resp_valid, 4'b0000);
        chk("arst_accept", accept_read_resp_packet, 1'b0);
        chk("arst_req_accept", req_accept, 4'b0000);
        at_neg();
        tick();
        rst_n = 1'b1;
        tick();
        read_resp_packet_valid = 1'b1;
        read_resp_packet_data = {16{32'hDEAD_0BAD}};
        at_neg();
        chk("orphan_accept", accept_read_resp_packet, 1'b1);
        chk("orphan_resp_valid", resp_valid, 4'b0000);
        tick();
        read_resp_packet_valid = 1'b0;
        at_neg();
        chk("orphan_err_set", err_orphan_resp, 1'b1);
        chk("orphan_outst", outstanding, 5'd0);
        repeat (3) tick();
        at_neg();
        chk("orphan_err_sticky", err_orphan_resp, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/abd_rd_arbiter.md
Name: abd_rd_arbiter

Overview:
- Round-robin scheduler that shares the single AmorphOS ABD read-request/read-response port between NUM_REQ read requesters (PCIS read path, app slots).
- Registers the granted request onto the ABD request channel and bounds in-flight reads with a credit counter.
- Routes the in-order ABD read responses back to the requester that issued each read, using a requester-index route FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 16, maximum reads granted but not yet returned. Power of two.
- LOG_OUTSTANDING, 4, log2(MAX_OUTSTANDING). Sets the route FIFO depth and the counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester read request valid.
- req_addr  in  NUM_REQ*64  per-requester 64-byte-aligned address; requester i uses bits [64i+63:64i].
- req_accept  out  NUM_REQ  one-hot grant; the request is consumed this cycle.
- read_req_packet_valid  out  1  ABD request valid.
- read_req_packet_addr  out  64  ABD request address.
- read_req_accept  in  1  ABD consumes the request.
- read_resp_packet_valid  in  1  ABD response valid.
- read_resp_packet_data  in  512  ABD response data.
- accept_read_resp_packet  out  1  response consumed.
- resp_valid  out  NUM_REQ  one-hot per-requester response valid.
- resp_data  out  512  response data, shared by all requesters.
- resp_accept  in  NUM_REQ  per-requester response ready.
- outstanding  out  LOG_OUTSTANDING+1  current credit usage.
- err_orphan_resp  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0) clears the following:
  - stage_valid=0, stage_addr=0, rr_ptr=0.
  - outstanding=0, route FIFO emptied, err_orphan_resp=0.
  - All outputs read 0.
  - In-flight reads are discarded; there is no recovery.
- Request stage: a single register holding the ABD request.
  - read_req_packet_valid=stage_valid and read_req_packet_addr=stage_addr, both driven directly from flops.
  - The stage can load when stage_valid=0 OR (read_req_packet_valid && read_req_accept), i.e. a same-cycle drain and refill is allowed.
- Grant condition, all must hold:
  - the stage can load;
  - outstanding < MAX_OUTSTANDING;
  - the route FIFO is not full;
  - at least one req_valid is set.
- Grant selection and effects:
  - The winner is the first set req_valid scanning from rr_ptr upward, modulo NUM_REQ.
  - On a grant: req_accept[winner]=1 combinationally; stage_addr<=req_addr[winner]; stage_valid<=1.
  - Also on a grant: the winner index is enqueued in the route FIFO, and rr_ptr<=(winner+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Latency: a request granted in cycle T is presented to ABD in cycle T+1. Back-to-back grants every cycle are sustained while ABD accepts every cycle.
- Stage drain without a grant: stage_valid<=0.
- Credit counter:
  - Incremented on grant.
  - Decremented on a routed response handshake.
  - Grant and response in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Response routing (ABD returns responses in issue order):
  - head = route FIFO head.
  - resp_valid[head] = read_resp_packet_valid && !route_empty; all other bits are 0.
  - resp_data = read_resp_packet_data.
  - accept_read_resp_packet = resp_accept[head] when the route FIFO is non-empty.
  - On the handshake the route FIFO is dequeued. A slow requester stalls all responses (head-of-line blocking; this is intended).
- Orphan response: read_resp_packet_valid=1 with the route FIFO empty.
  - accept_read_resp_packet=1, which drops the response.
  - err_orphan_resp<=1 and stays set until reset.
  - The credit counter is unchanged.
- Route FIFO simultaneous enqueue and dequeue: legal at any occupancy, including full (the dequeue frees the slot) and empty (the bypass is not required; the response waits one cycle).
- A requester deasserting req_valid without a grant is permitted; no state changes.

Decomposition:
- The following go in AOSF1Types:
  - ABDReadReq reuse for the stage;
  - the F1_ABDRdArb_NumReq and F1_ABDRdArb_MaxOutstanding constants;
  - the F1_ABDRdArb_RouteFIFO_Type selector.
- Sub-module: the route FIFO is one HullFIFO instance, configured as follows:
  - WIDTH = $clog2(NUM_REQ), LOG_DEPTH = LOG_OUTSTANDING;
  - reset_n tied to rst_n.
- The round-robin priority picker is a function inside the module, not a separate module.

Test Plan:
- Single requester:
  - Stimulus: req 2 issues addr 0x1000; ABD accepts immediately; response data D0 arrives 5 cycles later.
  - Required: read_req_packet_valid in cycle T+1 with addr 0x1000; resp_valid=4'b0100 with D0; outstanding goes 0→1→0.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold req_valid; ABD always accepts.
  - Required: grant order 0,1,2,3,0,1 on consecutive cycles; 6 grants in 6 cycles.
- Credit limit:
  - Stimulus: no responses returned; requester 0 requests continuously.
  - Required: exactly 16 grants; req_accept then held at 0; outstanding=16.
  - Then one response: exactly one further grant.
- Backpressure:
  - Stimulus: read_req_accept=0 for 10 cycles.
  - Required: stage_addr stable; one grant only; all other req_accept=0; progress resumes on accept.
- Response routing under stall:
  - Stimulus: grants issued in order 1,3,1; resp_accept[3]=0 for 4 cycles.
  - Required: first response goes to requester 1; the second is held at resp_valid=4'b1000 until accepted; the third goes to requester 1.
- Async reset mid-flight and orphan response:
  - Stimulus: rst_n pulsed low with 3 reads outstanding.
  - Required: all outputs 0 immediately, outstanding=0.
  - Then a response arrives with no grants outstanding: accept_read_resp_packet=1 and err_orphan_resp=1 stays set.
